la_capture_core: RTL and testbench
==================================

LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning captured sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning sample buffer depth; it SHALL be a power of two, minimum 4.
REQ-003 The block SHALL have derived parameter AW = log2(DEPTH), meaning address width.
REQ-004 The block SHALL have port CLK_IN  in  1  sample clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port DATA_I  in  DATA_W  probe data sampled every cycle.
REQ-007 The block SHALL have port ARM_I  in  1  single-cycle arm request.
REQ-008 The block SHALL have port ABORT_I  in  1  abort request; it wins over ARM_I.
REQ-009 The block SHALL have ports TRIG_MASK_I and TRIG_VAL_I  in  DATA_W each, meaning compare mask and compare value.
REQ-010 The block SHALL have port TRIG_EDGE_I  in  1, where 0 = level match and 1 = match rising edge.
REQ-011 The block SHALL have port PRE_CNT_I  in  AW  pre-trigger sample count.
REQ-012 The block SHALL have port RD_ADDR_I  in  AW  readout address.
REQ-013 The block SHALL have port RD_DATA_O  out  DATA_W  readout data.
REQ-014 The block SHALL have status outputs BUSY_O, TRIGGERED_O and DONE_O  out  1 each.
REQ-015 The block SHALL have outputs TRIG_ADDR_O and START_ADDR_O  out  AW each, meaning the trigger sample address and the oldest sample address.

Function
REQ-016 The block SHALL compute match = (((DATA_I ^ TRIG_VAL_I) & TRIG_MASK_I) == 0); with an all-zero mask, match is constantly 1.
REQ-017 The block SHALL register match into match_d every cycle in all states; in edge mode the trigger condition SHALL be match & ~match_d, otherwise match.
REQ-018 The block SHALL implement states IDLE, PRE, WAIT, POST and DONE.
REQ-019 In IDLE or DONE, ARM_I SHALL do all of the following: latch pre = min(PRE_CNT_I, DEPTH-1); set wr_ptr=0; clear TRIGGERED_O and DONE_O; go to PRE, or to WAIT when pre=0.
REQ-020 In PRE, the block SHALL write DATA_I to buf[wr_ptr] each cycle and increment wr_ptr; after pre writes it SHALL go to WAIT.
REQ-021 In PRE, the trigger condition SHALL be ignored.
REQ-022 In WAIT, the block SHALL write each cycle with wr_ptr wrapping modulo DEPTH.
REQ-023 On the trigger condition in WAIT, the sample of that cycle SHALL be written, TRIG_ADDR_O SHALL be set to its address, and the state SHALL go to POST (or DONE if DEPTH-pre = 1).
REQ-024 In POST, the block SHALL keep writing until exactly DEPTH-pre samples have been stored, counting the trigger sample, and then go to DONE.
REQ-025 On entry to DONE, START_ADDR_O SHALL be (TRIG_ADDR_O - pre) mod DEPTH, and writes SHALL stop.
REQ-026 TRIGGERED_O SHALL assert the cycle after the trigger sample is written and hold until re-arm, abort or reset.
REQ-027 DONE_O SHALL assert the cycle after the final write and hold until re-arm, abort or reset.
REQ-028 BUSY_O SHALL be 1 in PRE, WAIT and POST.
REQ-029 ARM_I while BUSY_O=1 SHALL be ignored.
REQ-030 ABORT_I in any state SHALL force IDLE next cycle and clear TRIGGERED_O and DONE_O; buffer contents SHALL be retained.
REQ-031 Simultaneous ARM_I and ABORT_I SHALL result in IDLE.
REQ-032 RD_DATA_O SHALL be registered with 1-cycle latency, so RD_DATA_O(t+1) = buf[RD_ADDR_I(t)], in any state.
REQ-033 A read of the address being written in the same cycle SHALL return the old contents.
REQ-034 In DONE, TRIG_ADDR_O and START_ADDR_O SHALL be stable.
REQ-035 TRIG_ADDR_O and START_ADDR_O SHALL be updated only on trigger and on DONE entry respectively.

Reset
REQ-036 When RST_N is 0, the block SHALL asynchronously set state=IDLE, wr_ptr=0, match_d=0, and BUSY_O, TRIGGERED_O, DONE_O, TRIG_ADDR_O, START_ADDR_O and RD_DATA_O all to 0.
REQ-037 Buffer contents SHALL NOT be reset.
REQ-038 Reset deassertion SHALL take effect synchronously at the next CLK_IN edge.
REQ-039 Reset mid-capture SHALL abandon the capture with no further writes.

Verification (DATA_W=6, DEPTH=16)
REQ-040 The bench SHALL cover: DATA_I = counter 0,1,2,..., mask=3F, val=0A, level, PRE_CNT=4, ARM at count 0 -> TRIG_ADDR_O=10, START_ADDR_O=6, DONE_O after 12 post samples; reading from START_ADDR_O wraps to give 6..21.
REQ-041 The bench SHALL cover: val matches during PRE only (PRE_CNT=8, match at sample 3) -> no trigger; trigger only on the next in-WAIT match.
REQ-042 The bench SHALL cover: edge mode with DATA_I held at the match value from arm -> exactly one trigger per 0->1 transition; a held level SHALL NOT retrigger, and with match_d=1 at WAIT entry there SHALL be no trigger.
REQ-043 The bench SHALL cover: mask=00, PRE_CNT=0 -> trigger on the first WAIT cycle, TRIG_ADDR_O=0, START_ADDR_O=0, DONE_O after 16 writes.
REQ-044 The bench SHALL cover: PRE_CNT=15 (maximum) -> DONE_O the cycle after the trigger write, START_ADDR_O=(TRIG_ADDR_O+1) mod 16.
REQ-045 The bench SHALL cover: ABORT_I in POST, or RST_N low mid-WAIT -> IDLE, with BUSY_O, TRIGGERED_O and DONE_O =0 and no further buffer writes; ARM_I while BUSY_O is ignored.

Source files
------------

// File: rtl/la_capture_core.sv
// la_capture_core: triggered logic-analyzer capture engine with a circular sample buffer
module la_capture_core #(
  parameter int DATA_W = 6,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DATA_I,
  input  logic              ARM_I,
  input  logic              ABORT_I,
  input  logic [DATA_W-1:0] TRIG_MASK_I,
  input  logic [DATA_W-1:0] TRIG_VAL_I,
  input  logic              TRIG_EDGE_I,
  input  logic [AW-1:0]     PRE_CNT_I,
  input  logic [AW-1:0]     RD_ADDR_I,
  output logic [DATA_W-1:0] RD_DATA_O,
  output logic              BUSY_O,
  output logic              TRIGGERED_O,
  output logic              DONE_O,
  output logic [AW-1:0]     TRIG_ADDR_O,
  output logic [AW-1:0]     START_ADDR_O
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, pre_q, pre_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d, start_addr_q, start_addr_d;
  logic triggered_q, triggered_d, match_prev_q, match_prev_d;
  logic match, trig, we;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem [DEPTH];
  // Trigger qualification, capture sequencing and buffer write control.
  // The final POST write lands one slot before the oldest sample, i.e. at trig_addr - pre - 1.
  always_comb begin
    match = ((DATA_I ^ TRIG_VAL_I) & TRIG_MASK_I) == '0;
    trig = TRIG_EDGE_I ? match & ~match_prev_q : match;
    match_prev_d = match;
    rd_data_d = mem[RD_ADDR_I];
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    pre_d = pre_q;
    trig_addr_d = trig_addr_q;
    start_addr_d = start_addr_q;
    triggered_d = triggered_q;
    we = 1'b0;
    if (ABORT_I) begin
      state_d = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (ARM_I) begin
          pre_d = PRE_CNT_I;
          wr_ptr_d = '0;
          triggered_d = 1'b0;
          state_d = PRE_CNT_I == '0 ? S_WAIT : S_PRE;
        end
        S_PRE: begin
          we = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d = wr_ptr_q + 1'b1 == pre_q ? S_WAIT : S_PRE;
        end
        S_WAIT: begin
          we = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            state_d = &pre_q ? S_DONE : S_POST;
            start_addr_d = &pre_q ? wr_ptr_q - pre_q : start_addr_q;
          end
        end
        S_POST: begin
          we = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == trig_addr_q - pre_q - 1'b1) begin
            state_d = S_DONE;
            start_addr_d = trig_addr_q - pre_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // Control and status registers with asynchronous reset.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      pre_q <= '0;
      trig_addr_q <= '0;
      start_addr_q <= '0;
      triggered_q <= 1'b0;
      match_prev_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      pre_q <= pre_d;
      trig_addr_q <= trig_addr_d;
      start_addr_q <= start_addr_d;
      triggered_q <= triggered_d;
      match_prev_q <= match_prev_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Sample buffer keeps its contents across reset and abort.
  always_ff @(posedge CLK_IN) begin
    if (we) mem[wr_ptr_q] <= DATA_I;
  end
  assign RD_DATA_O = rd_data_q;
  assign BUSY_O = state_q inside {S_PRE, S_WAIT, S_POST};
  assign TRIGGERED_O = triggered_q;
  assign DONE_O = state_q == S_DONE;
  assign TRIG_ADDR_O = trig_addr_q;
  assign START_ADDR_O = start_addr_q;
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed capture scenarios checked against a sample-count model
module tb_la_capture_core;
  logic       CLK_IN = 1'b0;
  logic       RST_N = 1'b0;
  logic [5:0] DATA_I = '0;
  logic       ARM_I = 1'b0;
  logic       ABORT_I = 1'b0;
  logic [5:0] TRIG_MASK_I = '0;
  logic [5:0] TRIG_VAL_I = '0;
  logic       TRIG_EDGE_I = 1'b0;
  logic [3:0] PRE_CNT_I = '0;
  logic [3:0] RD_ADDR_I = '0;
  logic [5:0] RD_DATA_O;
  logic       BUSY_O, TRIGGERED_O, DONE_O;
  logic [3:0] TRIG_ADDR_O, START_ADDR_O;

  la_capture_core #(.DATA_W(6), .DEPTH(16)) dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .DATA_I(DATA_I), .ARM_I(ARM_I), .ABORT_I(ABORT_I),
    .TRIG_MASK_I(TRIG_MASK_I), .TRIG_VAL_I(TRIG_VAL_I), .TRIG_EDGE_I(TRIG_EDGE_I),
    .PRE_CNT_I(PRE_CNT_I), .RD_ADDR_I(RD_ADDR_I), .RD_DATA_O(RD_DATA_O), .BUSY_O(BUSY_O),
    .TRIGGERED_O(TRIGGERED_O), .DONE_O(DONE_O), .TRIG_ADDR_O(TRIG_ADDR_O), .START_ADDR_O(START_ADDR_O)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_chk = 0;
  int n_pass = 0;
  bit run = 0;

  // model: capture described by how many samples were stored since arm
  bit cap, trg, dn, mprev, mrd_v;
  int k, npost, pre, mtrig, mstart;
  logic [5:0] mrd;
  logic [5:0] mmem [16];
  bit [15:0] mval = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    cap = 0; trg = 0; dn = 0; mprev = 0; mtrig = 0; mstart = 0; mrd = '0; mrd_v = 1;
  endtask

  task automatic model_step();
    bit m, cond, nv;
    logic [5:0] nrd;
    if (!RST_N) begin model_reset(); return; end
    m = ((DATA_I ^ TRIG_VAL_I) & TRIG_MASK_I) == 6'd0;
    cond = TRIG_EDGE_I ? (m && !mprev) : m;
    nrd = mmem[RD_ADDR_I];
    nv = mval[RD_ADDR_I];
    if (ABORT_I) begin
      cap = 0; trg = 0; dn = 0;
    end else if (!cap && ARM_I) begin
      pre = int'(PRE_CNT_I); k = 0; npost = 0; trg = 0; dn = 0; cap = 1;
    end else if (cap) begin
      mmem[k % 16] = DATA_I;
      mval[k % 16] = 1'b1;
      if (!trg && k >= pre && cond) begin trg = 1; mtrig = k % 16; end
      if (trg) npost++;
      if (npost == 16 - pre) begin cap = 0; dn = 1; mstart = (mtrig - pre + 16) % 16; end
      k++;
    end
    mprev = m;
    mrd = nrd;
    mrd_v = nv;
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    model_step();
    #1;
  endtask

  always @(negedge CLK_IN) begin
    if (run) begin
      chk("busy", BUSY_O, cap);
      chk("triggered", TRIGGERED_O, trg);
      chk("done", DONE_O, dn);
      chk("trig_addr", TRIG_ADDR_O, mtrig);
      chk("start_addr", START_ADDR_O, mstart);
      if (mrd_v) chk("rd_data", RD_DATA_O, mrd);
    end
  end

  function automatic logic [5:0] gen(input int s, input int c);
    case (s)
      1: return 6'(c);
      2: return 6'(c % 12);
      3: return (c == 8 || c == 12) ? 6'h00 : 6'h15;
      4: return 6'(c * 7);
      5: return (c == 20) ? 6'h2A : 6'(c & 31);
      6: return 6'(c | 32);
      default: return 6'(c | 16);
    endcase
  endfunction

  task automatic capture(input int s, input int p, input logic [5:0] mask, input logic [5:0] val,
                         input logic edge_m, input int limit, input int abort_c, input int rst_c,
                         output int cyc, output int tseen);
    TRIG_MASK_I = mask; TRIG_VAL_I = val; TRIG_EDGE_I = edge_m; PRE_CNT_I = p[3:0];
    DATA_I = gen(s, 0); ARM_I = 1'b1;
    tick();
    ARM_I = 1'b0;
    tseen = -1;
    cyc = 0;
    while (!DONE_O && cyc < limit) begin
      DATA_I = gen(s, cyc);
      ARM_I = (s == 2 && cyc == 12);
      PRE_CNT_I = ARM_I ? 4'd2 : p[3:0];
      ABORT_I = (cyc == abort_c);
      if (cyc == rst_c) begin RST_N = 1'b0; model_reset(); end
      if (cyc == rst_c + 2) RST_N = 1'b1;
      tick();
      cyc++;
      if (TRIGGERED_O && tseen < 0) tseen = cyc;
    end
    ARM_I = 1'b0; ABORT_I = 1'b0; PRE_CNT_I = p[3:0];
  endtask

  task automatic rd(input int a, output logic [5:0] v);
    RD_ADDR_I = a[3:0];
    tick();
    v = RD_DATA_O;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, ts;
    logic [5:0] v;
    model_reset();
    run = 1;
    repeat (3) tick();
    chk("rst_busy", BUSY_O, 0);
    chk("rst_trig", TRIGGERED_O, 0);
    chk("rst_done", DONE_O, 0);
    chk("rst_taddr", TRIG_ADDR_O, 0);
    chk("rst_saddr", START_ADDR_O, 0);
    chk("rst_rd", RD_DATA_O, 0);
    RST_N = 1'b1;
    tick();

    capture(1, 4, 6'h3F, 6'h0A, 1'b0, 40, -1, -1, cyc, ts);
    chk("s1_cycles", cyc, 22);
    chk("s1_tseen", ts, 11);
    chk("s1_taddr", TRIG_ADDR_O, 10);
    chk("s1_saddr", START_ADDR_O, 6);
    for (int i = 0; i < 16; i++) begin
      rd((6 + i) % 16, v);
      chk("s1_readout", v, 6 + i);
    end

    capture(2, 8, 6'h3F, 6'h03, 1'b0, 40, -1, -1, cyc, ts);
    chk("s2_tseen", ts, 16);
    chk("s2_cycles", cyc, 23);
    chk("s2_taddr", TRIG_ADDR_O, 15);
    chk("s2_saddr", START_ADDR_O, 7);

    capture(3, 2, 6'h3F, 6'h15, 1'b1, 40, -1, -1, cyc, ts);
    chk("s3_tseen", ts, 10);
    chk("s3_cycles", cyc, 23);
    chk("s3_taddr", TRIG_ADDR_O, 9);
    chk("s3_saddr", START_ADDR_O, 7);

    capture(4, 0, 6'h00, 6'h2B, 1'b0, 40, -1, -1, cyc, ts);
    chk("s4_tseen", ts, 1);
    chk("s4_cycles", cyc, 16);
    chk("s4_taddr", TRIG_ADDR_O, 0);
    chk("s4_saddr", START_ADDR_O, 0);

    capture(5, 15, 6'h3F, 6'h2A, 1'b0, 40, -1, -1, cyc, ts);
    chk("s5_tseen", ts, 21);
    chk("s5_cycles", cyc, 21);
    chk("s5_done", DONE_O, 1);
    chk("s5_taddr", TRIG_ADDR_O, 4);
    chk("s5_saddr", START_ADDR_O, (int'(TRIG_ADDR_O) + 1) % 16);
    chk("s5_saddr_lit", START_ADDR_O, 5);

    capture(6, 4, 6'h3F, 6'h2A, 1'b0, 16, 13, -1, cyc, ts);
    chk("s6_tseen", ts, 11);
    chk("s6_cycles", cyc, 16);
    chk("s6_busy", BUSY_O, 0);
    chk("s6_trig", TRIGGERED_O, 0);
    chk("s6_done", DONE_O, 0);
    rd(12, v);
    chk("s6_last_write", v, 44);
    rd(13, v);
    chk("s6_no_write", v, 13);

    ARM_I = 1'b1; ABORT_I = 1'b1;
    tick();
    ARM_I = 1'b0; ABORT_I = 1'b0;
    chk("arm_abort_busy", BUSY_O, 0);

    capture(7, 2, 6'h3F, 6'h3F, 1'b0, 10, -1, 6, cyc, ts);
    chk("s7_cycles", cyc, 10);
    chk("s7_tseen", ts, -1);
    chk("s7_busy", BUSY_O, 0);
    chk("s7_taddr", TRIG_ADDR_O, 0);
    rd(5, v);
    chk("s7_last_write", v, 21);
    rd(6, v);
    chk("s7_no_write", v, 38);

    for (int i = 0; i < 16; i++) rd(i, v);
    tick();
    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
